// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Groups the IF-stage control, instruction-memory and IF/ID signals.
//   Names carry i_/o_ from the fetch unit's point of view.
//   Modports:
//     master : fetch unit side (drives imem request and IF/ID outputs)
//     slave  : environment side (hazard unit, EX redirect, imem, IF/ID)
//   Signals:
//     i_stall, i_branch_taken, i_branch_target[31:0]  hazard / EX controls
//     o_imem_read, o_imem_address[31:0]               memory request
//     i_imem_readdata[31:0], i_imem_busywait          memory response
//     o_instruction, o_pc_direct, o_pc_plus_4 [31:0]  to IF/ID
//     o_fetch_busywait                                0 = IF/ID may capture
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        o_imem_read;
    logic [31:0] o_imem_address;
    logic [31:0] i_imem_readdata;
    logic        i_imem_busywait;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_direct;
    logic [31:0] o_pc_plus_4;
    logic        o_fetch_busywait;

    modport master (
        input  i_stall, i_branch_taken, i_branch_target,
        input  i_imem_readdata, i_imem_busywait,
        output o_imem_read, o_imem_address,
        output o_instruction, o_pc_direct, o_pc_plus_4, o_fetch_busywait
    );

    modport slave (
        output i_stall, i_branch_taken, i_branch_target,
        output i_imem_readdata, i_imem_busywait,
        input  o_imem_read, o_imem_address,
        input  o_instruction, o_pc_direct, o_pc_plus_4, o_fetch_busywait
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   IF stage: owns the PC, runs the instruction-memory read handshake and
//   presents {instruction, PC, PC+4} to the IF/ID register with a busywait.
//   Handles stalls, EX redirects and redirects arriving mid-access.
//   Ports:
//     i_clk    clock, all state updates on posedge
//     i_reset  synchronous active-high reset
//     bus      instruction_fetch_unit_if.master (controls, imem, IF/ID)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_REQ    | read request issued for PC; deliver word when memory is done
//   S_HOLD   | word captured during a stall; memory idle until stall drops
//   S_SQUASH | redirect arrived mid-access; drain it and drop the data
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    instruction_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_HOLD   = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_redirect_pc;

    logic [31:0] w_target;
    logic [31:0] w_pc_plus_4;

    // Redirect targets are always word aligned.
    assign w_target    = bus.i_branch_target & ~32'd3;
    assign w_pc_plus_4 = r_pc + 32'd4;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_hold_instr  <= NOP_INSTR;
            r_redirect_pc <= RESET_PC;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.i_branch_taken) begin
                        if (!bus.i_imem_busywait) begin
                            r_pc <= w_target;
                        end else begin
                            // Access still in flight: keep the address stable
                            // and remember where to go once it completes.
                            r_redirect_pc <= w_target;
                            r_state       <= S_SQUASH;
                        end
                    end else if (!bus.i_imem_busywait) begin
                        if (!bus.i_stall) begin
                            r_pc <= w_pc_plus_4;
                        end else begin
                            r_hold_instr <= bus.i_imem_readdata;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.i_branch_taken) begin
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end else if (!bus.i_stall) begin
                        r_pc    <= w_pc_plus_4;
                        r_state <= S_REQ;
                    end
                end
                S_SQUASH: begin
                    if (bus.i_branch_taken) begin
                        r_redirect_pc <= w_target;
                    end
                    if (!bus.i_imem_busywait) begin
                        // A redirect in the completing cycle is the newest one.
                        r_pc    <= bus.i_branch_taken ? w_target : r_redirect_pc;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    assign bus.o_imem_address = r_pc;
    assign bus.o_pc_direct    = r_pc;
    assign bus.o_pc_plus_4    = w_pc_plus_4;
    assign bus.o_imem_read    = !i_reset && (r_state != S_HOLD);

    // A redirect always pushes a bubble into IF/ID, even under a stall, so the
    // wrong-path word in ID is replaced.
    always_comb begin
        bus.o_instruction    = NOP_INSTR;
        bus.o_fetch_busywait = 1'b1;
        if (!i_reset) begin
            if (bus.i_branch_taken) begin
                bus.o_instruction    = NOP_INSTR;
                bus.o_fetch_busywait = 1'b0;
            end else if (r_state == S_REQ && !bus.i_imem_busywait && !bus.i_stall) begin
                bus.o_instruction    = bus.i_imem_readdata;
                bus.o_fetch_busywait = 1'b0;
            end else if (r_state == S_HOLD && !bus.i_stall) begin
                bus.o_instruction    = r_hold_instr;
                bus.o_fetch_busywait = 1'b0;
            end
        end
    end

endmodule
